// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types, including fetch front-end types
// Purpose: common word type plus the fetch FSM state, buffer entry and default depth.
// Ports: none (package).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int FETCH_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction buffer for the fetch unit
// Purpose: DEPTH-entry FIFO of fetch_entry_t; flush beats push and pop.
// Ports: CLK, nRST (async active-low), push/wdata, pop/rdata, flush,
//        full, empty, count.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH (a power of two).
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, icache handshake, buffer
// Purpose: fetch words over iREN/iwait, buffer them, present one per cycle with its PC;
//          handles redirect, stall and sticky halt.
// Ports: CLK, nRST; icache side iREN, iaddr, iwait, iload; control side stall,
//        redirect, redirect_addr, halt; decode side instruction, instr_pc, npc, valid.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = FETCH_DEPTH
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] npc,
    output logic        valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        paddr_q, paddr_d;   // address of the request in flight
    logic         pend_q, pend_d;     // a raised request has not completed yet

    logic                   push, pop, flush, done;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t           head, wentry;
    word_t                  target;

    assign target = {redirect_addr[31:2], 2'b00};
    assign iaddr  = pend_q ? paddr_q : pc_q;
    assign wentry = '{instr: iload, pc: iaddr};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        paddr_d = paddr_q;
        pend_d  = pend_q;
        iREN    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                iREN = pend_q || !full;
                done = iREN && !iwait;
                if (halt) begin
                    state_d = HALTED;
                    flush   = 1'b1;
                    pend_d  = 1'b0;
                end else if (redirect) begin
                    // Completing data is dropped; a still-busy request must be drained.
                    flush  = 1'b1;
                    pc_d   = target;
                    pend_d = 1'b0;
                    if (iREN && iwait) begin
                        state_d = FLUSH;
                        pend_d  = 1'b1;
                        paddr_d = iaddr;
                    end
                end else begin
                    pop = valid && !stall;
                    if (done) begin
                        push   = 1'b1;
                        pc_d   = pc_q + 32'd4;
                        pend_d = 1'b0;
                    end else if (iREN) begin
                        pend_d  = 1'b1;
                        paddr_d = iaddr;
                    end
                end
            end
            FLUSH: begin
                iREN = 1'b1;
                if (halt) begin
                    state_d = HALTED;
                    flush   = 1'b1;
                    pend_d  = 1'b0;
                end else begin
                    if (redirect) pc_d = target;
                    if (!iwait) begin
                        state_d = FETCH;
                        pend_d  = 1'b0;
                    end
                end
            end
            HALTED: flush = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= PC_INIT;
            paddr_q <= PC_INIT;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            paddr_q <= paddr_d;
            pend_q  <= pend_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign valid       = !empty;
    assign instruction = valid ? head.instr : 32'h0;
    assign instr_pc    = valid ? head.pc : 32'h0;
    assign npc         = instr_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        halt = 1'b0;
    logic [31:0] instruction, instr_pc, npc;
    logic        valid;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.PC_INIT(32'h0), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
        .iload(iload), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .instruction(instruction),
        .instr_pc(instr_pc), .npc(npc), .valid(valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        bit          iw;
        bit          rd;
        logic [31:0] ra;
        bit          hl;
        bit          e_iren;
        logic [31:0] e_iaddr;
        bit          e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_npc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, st, iw, rd, input logic [31:0] ra, input bit hl,
                       input bit e_iren, input logic [31:0] e_iaddr, input bit e_valid,
                       input logic [31:0] e_ipc, input logic [31:0] e_npc);
        vec_t v;
        v = '{rst, st, iw, rd, ra, hl, e_iren, e_iaddr, e_valid, e_ipc, e_npc};
        vecs.push_back(v);
    endtask

    // Reference model state: plain queue of buffered entries plus handshake flags.
    bit           m_idle, m_halted, m_flush, m_pend;
    logic [31:0]  m_pc, m_paddr;
    fetch_entry_t m_q[$];
    bit           m_iren, m_valid;
    logic [31:0]  m_iaddr, m_ipc, m_instr;

    task automatic model_reset();
        m_idle = 1; m_halted = 0; m_flush = 0; m_pend = 0;
        m_pc = 32'h0; m_paddr = 32'h0;
        m_q.delete();
    endtask

    task automatic model_outputs();
        m_iren  = !m_idle && !m_halted && (m_flush || m_pend || m_q.size() < DEPTH);
        m_iaddr = m_pend ? m_paddr : m_pc;
        m_valid = m_q.size() > 0;
        m_ipc   = m_valid ? m_q[0].pc : 32'h0;
        m_instr = m_valid ? m_q[0].instr : 32'h0;
    endtask

    task automatic model_step(input bit st, iw, rd, input logic [31:0] ra, input bit hl,
                              input logic [31:0] ld);
        fetch_entry_t e;
        if (m_idle) begin
            m_idle = 0;
        end else if (m_halted) begin
        end else if (hl) begin
            m_halted = 1; m_flush = 0; m_pend = 0; m_q.delete();
        end else if (m_flush) begin
            if (rd) m_pc = {ra[31:2], 2'b00};
            if (!iw) begin m_flush = 0; m_pend = 0; end
        end else if (rd) begin
            m_q.delete();
            m_pc = {ra[31:2], 2'b00};
            if (m_iren && iw) begin
                m_flush = 1; m_pend = 1; m_paddr = m_iaddr;
            end else begin
                m_pend = 0;
            end
        end else begin
            if (m_q.size() > 0 && !st) void'(m_q.pop_front());
            if (m_iren && !iw) begin
                e.instr = ld; e.pc = m_iaddr;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
                m_pend = 0;
            end else if (m_iren) begin
                m_pend = 1; m_paddr = m_iaddr;
            end
        end
    endtask

    initial begin
        // Stall fills the buffer, then drains in order.
        add(1,0,0,0,0,0, 0,32'h0,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h0,0,32'h0,32'h4);
        add(0,1,0,0,0,0, 1,32'h4,1,32'h0,32'h4);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,0, 0,32'h8,1,32'h0,32'h4);
        add(0,0,0,0,0,0, 0,32'h8,1,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h8,1,32'h4,32'h8);
        add(0,0,0,0,0,0, 1,32'hC,1,32'h8,32'hC);
        // Redirect while the cache is busy: old request drained, data dropped.
        add(1,0,0,0,0,0, 0,32'h0,0,32'h0,32'h4);
        add(0,0,1,1,32'h103,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,1,0,0,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,1,0,0,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h100,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h104,1,32'h100,32'h104);
        // Halt beats redirect; pc untouched afterwards.
        add(1,0,0,0,0,0, 0,32'h0,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,1,1,32'h200,1, 1,32'h4,1,32'h0,32'h4);
        add(0,0,0,0,0,0, 0,32'h4,0,32'h0,32'h4);
        add(0,0,0,1,32'h300,0, 0,32'h4,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 0,32'h4,0,32'h0,32'h4);
        // PC wrap at the top of the address space.
        add(1,0,0,0,0,0, 0,32'h0,0,32'h0,32'h4);
        add(0,0,0,1,32'hFFFF_FFFE,0, 1,32'h0,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'hFFFF_FFFC,0,32'h0,32'h4);
        add(0,0,0,0,0,0, 1,32'h0,1,32'hFFFF_FFFC,32'h0);
        add(0,0,0,0,0,0, 1,32'h4,1,32'h0,32'h4);

        foreach (vecs[i]) begin
            @(negedge CLK);
            if (vecs[i].rst) begin
                nRST = 1'b0; #2; nRST = 1'b1;
            end
            stall = vecs[i].st; iwait = vecs[i].iw; redirect = vecs[i].rd;
            redirect_addr = vecs[i].ra; halt = vecs[i].hl;
            #1;
            iload = pat(iaddr);
            check32($sformatf("v%0d_iREN", i), {31'b0, iREN}, {31'b0, vecs[i].e_iren});
            check32($sformatf("v%0d_iaddr", i), iaddr, vecs[i].e_iaddr);
            check32($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            check32($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
            check32($sformatf("v%0d_npc", i), npc, vecs[i].e_npc);
            check32($sformatf("v%0d_instruction", i), instruction,
                    vecs[i].e_valid ? pat(vecs[i].e_ipc) : 32'h0);
        end

        // Asynchronous reset in the middle of a pending request with data buffered.
        @(negedge CLK);
        nRST = 1'b0; #2; nRST = 1'b1;
        stall = 1'b1; iwait = 1'b0; redirect = 1'b0; halt = 1'b0;
        @(negedge CLK); #1; iload = pat(iaddr);
        @(negedge CLK); iwait = 1'b1;
        @(posedge CLK); #2;
        check32("pre_reset_iREN", {31'b0, iREN}, 32'h1);
        check32("pre_reset_valid", {31'b0, valid}, 32'h1);
        nRST = 1'b0;
        #1;
        check32("async_iREN", {31'b0, iREN}, 32'h0);
        check32("async_iaddr", iaddr, 32'h0);
        check32("async_valid", {31'b0, valid}, 32'h0);
        check32("async_instruction", instruction, 32'h0);
        check32("async_instr_pc", instr_pc, 32'h0);
        check32("async_npc", npc, 32'h4);

        // Randomized run against the reference model, starting from a fresh reset.
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        nRST = 1'b0; #2; nRST = 1'b1;
        model_reset();
        for (int c = 0; c < 700; c++) begin
            if (c > 0) @(negedge CLK);
            stall    = ($urandom_range(0, 2) == 0);
            iwait    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_addr = $urandom;
            halt     = (c == 650);
            #1;
            iload = $urandom;
            model_outputs();
            check32("rnd_iREN", {31'b0, iREN}, {31'b0, m_iren});
            check32("rnd_iaddr", iaddr, m_iaddr);
            check32("rnd_valid", {31'b0, valid}, {31'b0, m_valid});
            check32("rnd_instruction", instruction, m_instr);
            check32("rnd_instr_pc", instr_pc, m_ipc);
            check32("rnd_npc", npc, m_ipc + 32'd4);
            model_step(stall, iwait, redirect, redirect_addr, halt, iload);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end: owns the PC, requests words from the icache over the iREN/iwait handshake, and buffers them in a small FIFO.
- Presents one instruction per cycle on the `instruction` input of the control unit, tagged with its PC.
- Handles jump/branch redirects, decode stalls and halt, so the decoder always sees a valid word or a NOP.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset.
- DEPTH, 2, instruction buffer entries; must be a power of two, ≥2.

Ports:
- CLK  input  1  clock; rising edge active.
- nRST  input  1  asynchronous active-low reset.
- iREN  output  1  icache read request.
- iaddr  output  32  icache word address; bits [1:0] always 0.
- iwait  input  1  icache busy; a request completes in a cycle with iREN=1 and iwait=0.
- iload  input  32  icache read data; valid on the completing cycle.
- stall  input  1  decode cannot accept this cycle.
- redirect  input  1  taken branch, jump or jr; flush and refetch.
- redirect_addr  input  32  target PC; bits [1:0] ignored.
- halt  input  1  halt decoded by the control unit.
- instruction  output  32  head instruction to the control unit; 32'h0 (NOP) when invalid.
- instr_pc  output  32  PC of head entry; 0 when invalid.
- npc  output  32  instr_pc + 4, modulo 2^32.
- valid  output  1  head entry present.

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT; FIFO empty; state=IDLE.
  - iREN=0, iaddr=PC_INIT, valid=0, instruction=0, instr_pc=0, npc=4.
- States:
  - IDLE: one cycle after reset release, always → FETCH.
  - FETCH: normal operation.
  - FLUSH: drain a request in flight at redirect time.
  - HALTED: terminal; left only by reset.
- Request issue:
  - In FETCH, iREN=1 when a request is already pending or count<DEPTH; iaddr=pc.
  - Once raised, iREN and iaddr stay constant until the completing cycle; a request is never withdrawn.
- Completion (FETCH, iREN=1, iwait=0):
  - Push {iload, pc}; pc<=pc+4 (wraps at 2^32).
  - iREN may stay high next cycle for back-to-back fetch.
- Consume: when valid=1 and stall=0, pop the head at the clock edge.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Full (count==DEPTH): no new request starts; resumes the cycle after a pop.
- Empty: valid=0, instruction=0; a word completing this cycle appears at the head the next cycle (1-cycle fill latency).
- Redirect (halt=0), applied at the clock edge:
  - FIFO cleared; pc<=redirect_addr with bits [1:0]=00.
  - The pop that would otherwise occur this cycle is discarded with the flush.
  - If a request is pending with iwait=1: state→FLUSH, keep iREN=1 with the old iaddr until iwait=0, discard iload, then →FETCH.
  - If the request completes in the redirect cycle itself: discard the data, stay in FETCH.
- Redirect during FLUSH: update pc to the newest target; remain in FLUSH until the pending request completes.
- Halt:
  - Sticky → HALTED at the clock edge; iREN=0; FIFO cleared; valid=0.
  - Halt beats redirect and stall in the same cycle.
  - A pending cache request is abandoned; the cache tolerates iREN dropping on halt.
- Reset mid-request: everything returns to reset values immediately (async); no data from the old request is kept.

Decomposition:
- Add to cpu_types_pkg:
  - fetch_state_t enum {IDLE, FETCH, FLUSH, HALTED}.
  - fetch_entry_t struct {word_t instr; word_t pc;}.
  - FETCH_DEPTH constant, default 2.
- Reuse the package's existing word_t.
- Sub-module fetch_fifo(DEPTH):
  - Circular buffer of fetch_entry_t with push, pop, flush, full, empty and count.
  - Read and write pointers wrap modulo DEPTH; flush has priority over push and pop.
- fetch_unit holds the PC, FSM and handshake logic.

Test Plan:
- Reset release, iwait=0 always, iload=PC-derived pattern, stall=0 -> iREN first high the cycle after IDLE; iaddr 0,4,8,...; instruction/instr_pc stream in order; valid continuous after a 1-cycle fill.
- stall=1 for 5 cycles, iwait=0 -> exactly 2 words buffered; iREN=0 while full; on release the heads at PC 0x0, 0x4 pop in order; fetch resumes at 0x8.
- iwait=1 for 3 cycles with redirect to 0x0000_0103 in cycle 1 -> iaddr held at the old PC until iwait=0; that data is dropped; next request at 0x0000_0100; first valid instr_pc=0x100.
- Redirect and halt asserted together -> HALTED, iREN=0, valid=0 forever; pc not updated.
- pc=0xFFFF_FFFC fetch -> next iaddr=0x0000_0000; npc of the head =0x0000_0000.
- nRST pulsed low while iREN=1, iwait=1 and FIFO full -> outputs reach reset values asynchronously; iaddr=PC_INIT; restart matches the first scenario.
